// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared widths and read-owner encoding for the instruction memory arbiter.
package imem_arbiter_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 64;
    localparam int WAIT_W = 8;
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;
endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and memory buses of the arbiter; slave is the arbiter side.
interface imem_arbiter_if
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              f_req_i;
    logic [ADDR_W-1:0] f_addr_i;
    logic [DATA_W-1:0] f_data_o;
    logic              f_valid_o;
    logic              f_stall_o;
    logic              l_req_i;
    logic              l_we_i;
    logic [ADDR_W-1:0] l_addr_i;
    logic [DATA_W-1:0] l_wdata_i;
    logic              l_gnt_o;
    logic [DATA_W-1:0] l_rdata_o;
    logic              l_rvalid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_stall_o;
    logic [DATA_W-1:0] mem_data_i;

    modport slave (
        input  f_req_i, f_addr_i, l_req_i, l_we_i, l_addr_i, l_wdata_i, mem_data_i,
        output f_data_o, f_valid_o, f_stall_o, l_gnt_o, l_rdata_o, l_rvalid_o,
               mem_addr_o, mem_we_o, mem_wdata_o, mem_stall_o
    );
    modport master (
        output f_req_i, f_addr_i, l_req_i, l_we_i, l_addr_i, l_wdata_i, mem_data_i,
        input  f_data_o, f_valid_o, f_stall_o, l_gnt_o, l_rdata_o, l_rvalid_o,
               mem_addr_o, mem_we_o, mem_wdata_o, mem_stall_o
    );
endinterface

// File: rtl/imem_arb_aging.sv
// imem_arb_aging: saturating count of denied loader cycles; force_o demands a loader grant.
module imem_arb_aging
    import imem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clock_i,
    input  logic resetn_i,
    input  logic pend_i,
    input  logic gnt_i,
    output logic force_o
);
    logic [WAIT_W-1:0] cnt_q, cnt_d;

    assign force_o = cnt_q == WAIT_W'(MAX_WAIT);

    always_comb
        cnt_d = (!pend_i || gnt_i) ? '0 : (force_o ? cnt_q : cnt_q + 1'b1);

    always_ff @(posedge clock_i or negedge resetn_i)
        if (!resetn_i) cnt_q <= '0;
        else           cnt_q <= cnt_d;
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: fetch-priority arbiter for the shared instruction memory with loader aging.
// IMEM_ARB_PERF_EN adds fetch-stall and loader-grant event counters.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 8
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    imem_arbiter_if.slave       bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_fstall_o,
    output logic [31:0]         perf_lgnt_o
`endif
);
    owner_e            own_q, own_d;
    logic [ADDR_W-1:0] addr_q;
    logic              l_gnt, f_gnt, force_w;

    // Grants are gated by reset so an asserted reset kills a write immediately.
    assign l_gnt = resetn_i & bus.l_req_i & (!bus.f_req_i | force_w);
    assign f_gnt = resetn_i & bus.f_req_i & !l_gnt;

    assign bus.l_gnt_o     = l_gnt;
    assign bus.f_stall_o   = bus.f_req_i & !f_gnt;
    assign bus.mem_addr_o  = l_gnt ? bus.l_addr_i : (f_gnt ? bus.f_addr_i : addr_q);
    assign bus.mem_we_o    = l_gnt & bus.l_we_i;
    assign bus.mem_wdata_o = bus.l_wdata_i;
    assign bus.mem_stall_o = (own_q == OWN_FETCH) & bus.f_stall_o;
    assign bus.f_valid_o   = own_q == OWN_FETCH;
    assign bus.l_rvalid_o  = own_q == OWN_LOAD;
    assign bus.f_data_o    = bus.f_valid_o ? bus.mem_data_i : {DATA_W{1'b0}};
    assign bus.l_rdata_o   = bus.l_rvalid_o ? bus.mem_data_i : {DATA_W{1'b0}};

    always_comb
        own_d = l_gnt ? (bus.l_we_i ? OWN_NONE : OWN_LOAD) : (f_gnt ? OWN_FETCH : OWN_NONE);

    always_ff @(posedge clock_i or negedge resetn_i)
        if (!resetn_i) begin
            own_q  <= OWN_NONE;
            addr_q <= '0;
        end else begin
            own_q  <= own_d;
            addr_q <= bus.mem_addr_o;
        end

    imem_arb_aging #(.MAX_WAIT(MAX_WAIT)) u_aging (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .pend_i   (bus.l_req_i),
        .gnt_i    (l_gnt),
        .force_o  (force_w)
    );

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_fstall_q, perf_lgnt_q;

    always_ff @(posedge clock_i or negedge resetn_i)
        if (!resetn_i) begin
            perf_fstall_q <= '0;
            perf_lgnt_q   <= '0;
        end else begin
            perf_fstall_q <= perf_fstall_q + 32'(bus.f_stall_o);
            perf_lgnt_q   <= perf_lgnt_q + 32'(l_gnt);
        end

    assign perf_fstall_o = perf_fstall_q;
    assign perf_lgnt_o   = perf_lgnt_q;
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: table-driven bench with a read-return scoreboard for imem_arbiter.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    typedef struct {
        logic        f_req;
        logic [9:0]  f_addr;
        logic        l_req;
        logic        l_we;
        logic [9:0]  l_addr;
        logic [63:0] l_wdata;
        logic        e_gnt;
        logic        e_stall;
        logic        e_we;
        logic        e_mstall;
        logic [9:0]  e_addr;
    } vec_t;

    typedef struct {
        owner_e      k;
        logic [63:0] d;
    } exp_t;

    logic clock_i = 1'b0;
    logic resetn_i = 1'b0;
    always #5 clock_i = ~clock_i;

    imem_arbiter_if bus ();
`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_fstall_o, perf_lgnt_o;
    logic [31:0] exp_fstall = '0, exp_lgnt = '0;
`endif

    imem_arbiter #(.MAX_WAIT(8)) dut (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .bus      (bus)
`ifdef IMEM_ARB_PERF_EN
        ,
        .perf_fstall_o (perf_fstall_o),
        .perf_lgnt_o   (perf_lgnt_o)
`endif
    );

    function automatic logic [63:0] pat(input logic [9:0] a);
        return {32'hC0DE_0000 + 32'(a), ~32'(a)};
    endfunction

    // Memory model: registered read, one cycle latency, old data on read-during-write.
    logic [63:0]   wmem [1024];
    logic [1023:0] written = '0;
    logic [63:0]   mem_q = '0;
    always @(posedge clock_i) begin
        if (bus.mem_we_o) begin
            wmem[bus.mem_addr_o]    <= bus.mem_wdata_o;
            written[bus.mem_addr_o] <= 1'b1;
        end
        mem_q <= written[bus.mem_addr_o] ? wmem[bus.mem_addr_o] : pat(bus.mem_addr_o);
    end
    assign bus.mem_data_i = mem_q;

    logic [63:0] shadow [1024];
    exp_t sb[$];
    vec_t tab[$];
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ret(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            chk(name, {bus.f_valid_o, bus.f_data_o, bus.l_rvalid_o, bus.l_rdata_o},
                {e.k == OWN_FETCH, e.k == OWN_FETCH ? e.d : 64'd0,
                 e.k == OWN_LOAD,  e.k == OWN_LOAD  ? e.d : 64'd0});
        end
    endtask

    function automatic vec_t r(input logic fq, input logic [9:0] fa, input logic lq, input logic lw,
                               input logic [9:0] la, input logic [63:0] wd, input logic g,
                               input logic s, input logic w, input logic ms, input logic [9:0] ea);
        vec_t v;
        v.f_req = fq; v.f_addr = fa; v.l_req = lq; v.l_we = lw; v.l_addr = la; v.l_wdata = wd;
        v.e_gnt = g; v.e_stall = s; v.e_we = w; v.e_mstall = ms; v.e_addr = ea;
        return v;
    endfunction

    // Streaming fetch from base against a loader read of la: 8 denials, forced grant, resume.
    task automatic add_force(input int base, input logic [9:0] la);
        for (int i = 0; i < 8; i++)
            tab.push_back(r(1, 10'(base + i), 1, 0, la, 0, 0, 0, 0, 0, 10'(base + i)));
        tab.push_back(r(1, 10'(base + 8), 1, 0, la, 0, 1, 1, 0, 1, la));
        tab.push_back(r(1, 10'(base + 8), 0, 0, 0, 0, 0, 0, 0, 0, 10'(base + 8)));
        tab.push_back(r(1, 10'(base + 9), 0, 0, 0, 0, 0, 0, 0, 0, 10'(base + 9)));
        tab.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'(base + 9)));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clock_i);
        bus.f_req_i = v.f_req; bus.f_addr_i = v.f_addr;
        bus.l_req_i = v.l_req; bus.l_we_i = v.l_we;
        bus.l_addr_i = v.l_addr; bus.l_wdata_i = v.l_wdata;
        #1;
        check_ret($sformatf("ret[%0d]", idx));
        chk($sformatf("l_gnt[%0d]", idx), 132'(bus.l_gnt_o), 132'(v.e_gnt));
        chk($sformatf("f_stall[%0d]", idx), 132'(bus.f_stall_o), 132'(v.e_stall));
        chk($sformatf("mem_we[%0d]", idx), 132'(bus.mem_we_o), 132'(v.e_we));
        chk($sformatf("mem_stall[%0d]", idx), 132'(bus.mem_stall_o), 132'(v.e_mstall));
        chk($sformatf("mem_addr[%0d]", idx), 132'(bus.mem_addr_o), 132'(v.e_addr));
        chk($sformatf("mem_wdata[%0d]", idx), 132'(bus.mem_wdata_o), 132'(v.l_wdata));
`ifdef IMEM_ARB_PERF_EN
        chk($sformatf("perf_fstall[%0d]", idx), 132'(perf_fstall_o), 132'(exp_fstall));
        chk($sformatf("perf_lgnt[%0d]", idx), 132'(perf_lgnt_o), 132'(exp_lgnt));
        exp_fstall += 32'(v.e_stall);
        exp_lgnt   += 32'(v.e_gnt);
`endif
        if (v.e_gnt && v.l_we) begin
            shadow[v.l_addr] = v.l_wdata;
            sb.push_back('{k: OWN_NONE, d: 64'd0});
        end else if (v.e_gnt)
            sb.push_back('{k: OWN_LOAD, d: shadow[v.l_addr]});
        else if (v.f_req && !v.e_stall)
            sb.push_back('{k: OWN_FETCH, d: shadow[v.f_addr]});
        else
            sb.push_back('{k: OWN_NONE, d: 64'd0});
    endtask

    task automatic run_tab();
        foreach (tab[i]) run_vec(tab[i], i);
        tab.delete();
    endtask

    task automatic drive_idle();
        bus.f_req_i = 0; bus.f_addr_i = '0; bus.l_req_i = 0; bus.l_we_i = 0;
        bus.l_addr_i = '0; bus.l_wdata_i = '0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = pat(10'(i));
        drive_idle();
        #3;
        chk("rst_ret", {bus.f_valid_o, bus.f_data_o, bus.l_rvalid_o, bus.l_rdata_o}, '0);
        chk("rst_gnt", 132'(bus.l_gnt_o), 0);
        chk("rst_addr", 132'(bus.mem_addr_o), 0);
        chk("rst_we", 132'(bus.mem_we_o), 0);
        chk("rst_mstall", 132'(bus.mem_stall_o), 0);
        @(negedge clock_i);
        resetn_i = 1'b1;
        sb.push_back('{k: OWN_NONE, d: 64'd0});

        for (int i = 0; i < 4; i++) tab.push_back(r(1, 10'(i), 0, 0, 0, 0, 0, 0, 0, 0, 10'(i)));
        tab.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd3));
        tab.push_back(r(0, 0, 1, 1, 10'h005, 64'hDEAD_BEEF_0000_0013, 1, 0, 1, 0, 10'h005));
        tab.push_back(r(1, 10'h005, 0, 0, 0, 0, 0, 0, 0, 0, 10'h005));
        tab.push_back(r(0, 0, 1, 0, 10'h005, 0, 1, 0, 0, 0, 10'h005));
        tab.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h005));
        add_force(10, 10'd3);
        add_force(0, 10'd9);
        run_tab();

`ifdef IMEM_ARB_PERF_EN
        @(negedge clock_i);
        force dut.perf_fstall_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_fstall_q;
        exp_fstall = 32'hFFFF_FFFF;
        add_force(40, 10'd3);
        run_tab();
`endif

        for (int i = 0; i < 3; i++)
            tab.push_back(r(1, 10'(30 + i), 1, 1, 10'd20, 64'h5555_AAAA_0000_0013, 0, 0, 0, 0, 10'(30 + i)));
        run_tab();
        @(negedge clock_i);
        bus.f_req_i = 0; bus.l_req_i = 1; bus.l_we_i = 1;
        bus.l_addr_i = 10'd20; bus.l_wdata_i = 64'h5555_AAAA_0000_0013;
        #1;
        check_ret("w_ret");
        chk("w_gnt", 132'(bus.l_gnt_o), 1);
        chk("w_we", 132'(bus.mem_we_o), 1);
        #2;
        resetn_i = 1'b0;
        bus.f_req_i = 1;
        #1;
        chk("ar_we", 132'(bus.mem_we_o), 0);
        chk("ar_gnt", 132'(bus.l_gnt_o), 0);
        chk("ar_fstall", 132'(bus.f_stall_o), 1);
        chk("ar_addr", 132'(bus.mem_addr_o), 0);
        chk("ar_mstall", 132'(bus.mem_stall_o), 0);
        chk("ar_ret", {bus.f_valid_o, bus.f_data_o, bus.l_rvalid_o, bus.l_rdata_o}, '0);
        chk("ar_wait_cnt", 132'(dut.u_aging.cnt_q), 0);
        sb.delete();
        @(posedge clock_i);
        @(negedge clock_i);
        drive_idle();
        resetn_i = 1'b1;
        sb.push_back('{k: OWN_NONE, d: 64'd0});
`ifdef IMEM_ARB_PERF_EN
        exp_fstall = '0;
        exp_lgnt   = '0;
`endif
        add_force(20, 10'd21);
        run_tab();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port, 64-bit-wide (two-instruction) instruction memory between two requesters.
  - Core fetch unit: read-only, latency-critical.
  - Loader/debug port: read/write, used for program load and memory inspection.
- Sits between core and inst_mem; drives the memory address, write and stall controls.
- Returns read data to whichever requester issued the access.
- Fetch has priority; an aging counter bounds loader starvation.

Parameters:
- ADDR_W, 10, memory word address width
- DATA_W, 64, memory word width (two 32-bit instructions)
- MAX_WAIT, 8, max consecutive cycles a pending loader request may be denied before forced grant; legal range 1..255

Ports:
- clock_i  in  1  system clock, rising edge
- resetn_i  in  1  asynchronous active-low reset
- f_req_i  in  1  fetch read request
- f_addr_i  in  ADDR_W  fetch word address
- f_data_o  out  DATA_W  fetch read data
- f_valid_o  out  1  f_data_o valid this cycle
- f_stall_o  out  1  fetch request not accepted this cycle; hold f_addr_i
- l_req_i  in  1  loader request
- l_we_i  in  1  loader write (1) / read (0)
- l_addr_i  in  ADDR_W  loader word address
- l_wdata_i  in  DATA_W  loader write data
- l_gnt_o  out  1  loader request accepted this cycle
- l_rdata_o  out  DATA_W  loader read data
- l_rvalid_o  out  1  l_rdata_o valid this cycle
- mem_addr_o  out  ADDR_W  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  DATA_W  memory write data
- mem_stall_o  out  1  memory output-hold (stall_i of inst_mem)
- mem_data_i  in  DATA_W  memory read data, registered, 1-cycle latency

Behaviour:
- Grant is combinational from the current request and state; acceptance happens on the rising edge.
- Grant rule each cycle:
  - Loader granted iff l_req_i and (!f_req_i or wait_cnt == MAX_WAIT); otherwise fetch granted when f_req_i.
  - No request: mem_addr_o holds the last value, mem_we_o = 0.
- Outputs:
  - f_stall_o = f_req_i & !fetch_granted.
  - l_gnt_o = loader_granted.
- Memory drive: the granted requester's address drives mem_addr_o. mem_we_o = loader_granted & l_we_i. mem_wdata_o = l_wdata_i.
- wait_cnt (8 bit):
  - Increments when l_req_i & !l_gnt_o.
  - Saturates at MAX_WAIT.
  - Clears on l_gnt_o or when l_req_i = 0.
- Read return (1-cycle latency): owner register rd_owner_q ∈ {NONE, FETCH, LOAD} is set at each accept.
  - Next cycle, mem_data_i routes to f_data_o/f_valid_o when rd_owner_q == FETCH.
  - Routes to l_rdata_o/l_rvalid_o when rd_owner_q == LOAD.
  - Loader writes set rd_owner_q = NONE; no rvalid follows a write.
- mem_stall_o = 1 when rd_owner_q == FETCH and f_stall_o is asserted. This preserves the in-flight fetch word in inst_mem while the loader steals the port.
  - While held, f_valid_o stays 1 and f_data_o is unchanged.
- Back-to-back: one accept per cycle, full throughput. Fetch streaming with no loader gives f_valid_o every cycle after the first.
- Simultaneous requests at reset release: fetch wins; wait_cnt starts counting.
- Reset (async, any cycle, including mid-write):
  - All valids, l_gnt_o, mem_we_o = 0. f_stall_o follows f_req_i.
  - mem_addr_o = 0, mem_stall_o = 0.
  - rd_owner_q = NONE, wait_cnt = 0.
  - Data outputs = 0.
  - In-flight reads are dropped; no valid is ever issued for an access accepted before reset.
- Address/data widths pass through; no arithmetic wrap is needed beyond wait_cnt saturation.

Optional Feature:
- Macro: IMEM_ARB_PERF_EN.
- Defined: adds outputs perf_fstall_o (32 bit) and perf_lgnt_o (32 bit).
  - perf_fstall_o counts cycles with f_stall_o = 1.
  - perf_lgnt_o counts loader grants.
  - Both wrap at 2^32, clear on reset, and increment in the same cycle as the event.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header (imem_arb_defs.vh):
  - Owner encoding localparams OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_LOAD = 2'd2.
  - Default ADDR_W/DATA_W constants shared with inst_mem.
- One natural sub-module: imem_arb_aging, the saturating wait counter and force-grant flag. Ports: clock_i, resetn_i, pend_i, gnt_i, force_o.

Test Plan:
1. Fetch only, f_addr_i = 0,1,2,... each cycle → f_stall_o = 0; f_valid_o = 1 from cycle 2 with f_data_o = mem[n-1]; l_gnt_o never asserted.
2. Loader write l_addr_i = 10'h005, l_wdata_i = 64'hDEAD_BEEF_0000_0013, f_req_i = 0 → l_gnt_o = 1, mem_we_o = 1 for one cycle; a later fetch of 5 returns that word.
3. Continuous fetch plus constant loader read of address 3, MAX_WAIT = 8 → loader denied 8 cycles, granted on 9th cycle; f_stall_o = 1 that cycle; l_rvalid_o next cycle with mem[3]; f_data_o held by mem_stall_o.
4. Fetch read of address 7 accepted, loader forced next cycle → f_valid_o stays 1 with mem[7] unchanged during the stall; fetch resumes afterward with no lost or duplicated word.
5. Assert resetn_i = 0 asynchronously mid-cycle during a loader write → mem_we_o drops immediately; after release no stale f_valid_o/l_rvalid_o; wait_cnt = 0.
6. With IMEM_ARB_PERF_EN: run scenario 3 → perf_fstall_o = 1, perf_lgnt_o = 1; preload counter near 2^32 − 1 via a long run or a force → wraps to 0.
